// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types and constants for the CPU instruction-trace buffer.
// TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp to every entry.
package cpu_trace_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int TRACE_DATA_W = 32;
  localparam int STAMP_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    POST,
    DONE,
    READ
  } trace_state_e;

  // Default-width view of one stored entry
  typedef struct packed {
    logic [TRACE_DATA_W-1:0] pc;
    logic [TRACE_DATA_W-1:0] instr;
    logic [REG_ADDR_W-1:0]   rd;
    logic [TRACE_DATA_W-1:0] result;
`ifdef TRACE_TIMESTAMP_EN
    logic [STAMP_W-1:0]      stamp;
`endif
  } trace_entry_t;

  function automatic int entry_width(input int data_w);
`ifdef TRACE_TIMESTAMP_EN
    return 3 * data_w + REG_ADDR_W + STAMP_W;
`else
    return 3 * data_w + REG_ADDR_W;
`endif
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Written as a plain array so synthesis maps it onto block or distributed RAM.
module trace_ram
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WIDTH  = 101
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular retired-instruction history with PC/forced trigger, post-trigger
// window and oldest-first valid/ready readout. Option: TRACE_TIMESTAMP_EN.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int POST_TRIG = 8,
  parameter int DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  retire,
  input  logic [DATA_W-1:0]     pc,
  input  logic [DATA_W-1:0]     instr,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0]     result,
  input  logic [DATA_W-1:0]     trig_pc,
  input  logic                  force_trig,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_pc,
  output logic [DATA_W-1:0]     out_instr,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_last,
`ifdef TRACE_TIMESTAMP_EN
  output logic [STAMP_W-1:0]    out_stamp,
`endif
  output logic                  busy,
  output logic                  triggered,
  output logic                  wrapped
);

  localparam int               ENTRY_W    = entry_width(DATA_W);
  localparam int               STAMP_BITS = ENTRY_W - 3 * DATA_W - REG_ADDR_W;
  localparam logic [PTR_W:0]   FULL       = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE        = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] POST_LAST  = PTR_W'(POST_TRIG - 1);

  trace_state_e state, state_nx;

  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nx, rd_ptr, rd_addr, read_start, post_cnt;
  logic [PTR_W:0]     count, count_nx, remaining;
  logic               triggered_q, wrapped_q, out_valid_q;
  logic               we, trig_hit, fire, last_fire, rd_en, session_end;
  logic [ENTRY_W-1:0] wr_data, rd_data;

  assign we          = retire && (state == ARMED || state == POST);
  assign trig_hit    = (state == ARMED) && ((retire && pc == trig_pc) || force_trig);
  assign fire        = out_valid_q && out_ready;
  assign last_fire   = fire && (remaining == ONE);
  assign wr_ptr_nx   = we ? wr_ptr + 1'b1 : wr_ptr;
  assign count_nx    = (we && count != FULL) ? count + 1'b1 : count;
  // When full the low count bits are zero, so the oldest entry sits at wr_ptr
  assign read_start  = wr_ptr_nx - count_nx[PTR_W-1:0];
  assign rd_en       = (state == READ) && (!out_valid_q || fire) && !last_fire;
  assign rd_addr     = fire ? rd_ptr + 1'b1 : rd_ptr;
  assign session_end = (state == READ && last_fire) || (state == DONE && count == '0);

`ifdef TRACE_TIMESTAMP_EN
  logic [STAMP_W-1:0] stamp;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stamp <= '0;
    end else begin
      stamp <= stamp + 1'b1;
    end
  end

  assign wr_data   = {pc, instr, rd, result, stamp};
  assign out_stamp = out_valid_q ? rd_data[STAMP_W-1:0] : '0;
`else
  assign wr_data   = {pc, instr, rd, result};
`endif

  trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W),
    .WIDTH  (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (arm) state_nx = ARMED;
      ARMED: if (trig_hit) state_nx = (POST_TRIG == 0) ? DONE : POST;
      POST:  if (retire && post_cnt == POST_LAST) state_nx = READ;
      DONE:  state_nx = (count == '0) ? IDLE : READ;
      READ:  if (last_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      remaining   <= '0;
      post_cnt    <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state  <= state_nx;
      wr_ptr <= wr_ptr_nx;
      count  <= count_nx;
      if (we && count == FULL) begin
        wrapped_q <= 1'b1;
      end

      if (trig_hit) begin
        triggered_q <= 1'b1;
        post_cnt    <= '0;
      end else if (state == POST && retire) begin
        post_cnt <= post_cnt + 1'b1;
      end

      // Readout window is latched from the post-write pointers on entry to READ
      if (state_nx == READ && state != READ) begin
        rd_ptr    <= read_start;
        remaining <= count_nx;
      end else if (fire) begin
        rd_ptr    <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      if (state != READ || last_fire) begin
        out_valid_q <= 1'b0;
      end else if (rd_en) begin
        out_valid_q <= 1'b1;
      end

      if (session_end || (state == IDLE && arm)) begin
        count       <= '0;
        wrapped_q   <= 1'b0;
        triggered_q <= 1'b0;
        post_cnt    <= '0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_valid_q && (remaining == ONE);
  assign out_result = out_valid_q ? rd_data[STAMP_BITS +: DATA_W] : '0;
  assign out_rd     = out_valid_q ? rd_data[STAMP_BITS + DATA_W +: REG_ADDR_W] : '0;
  assign out_instr  = out_valid_q ? rd_data[STAMP_BITS + DATA_W + REG_ADDR_W +: DATA_W] : '0;
  assign out_pc     = out_valid_q ? rd_data[STAMP_BITS + 2 * DATA_W + REG_ADDR_W +: DATA_W] : '0;
  assign busy       = (state != IDLE);
  assign triggered  = triggered_q;
  assign wrapped    = wrapped_q;

endmodule
